// File: rtl/seq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_divider: radix-2 restoring divider, one quotient bit per cycle,      |
// | signed/unsigned with truncate-toward-zero and divide-by-zero handling.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;

  assign w_a_neg = signed_mode & dividend[WIDTH-1];
  assign w_b_neg = signed_mode & divisor[WIDTH-1];
  // Negating MIN yields MIN, which read as unsigned is the correct magnitude.
  assign w_a_mag = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag = w_b_neg ? (~divisor + 1'b1) : divisor;

  // The stored remainder stays below the divisor, so only the shifted trial
  // value needs the extra bit for the compare.
  assign w_shift = {rem_q, quo_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, dvs_q});

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = w_a_mag;
            dvs_d   = w_b_mag;
            cnt_d   = CNT_INIT;
            qneg_d  = w_a_neg ^ w_b_neg;
            rneg_d  = w_a_neg;
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_ge) begin
          rem_d = w_shift[WIDTH-1:0] - dvs_q;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = w_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quotient_d  = qneg_q ? (~quo_q + 1'b1) : quo_q;
        remainder_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
        dbz_d       = 1'b0;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_divider: directed and randomised checks of seq_divider, WIDTH=32. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_seq_divider;
  localparam int W = 32;
  localparam int LAT_NORM = W + 2;
  localparam int LAT_DBZ  = 1;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  int           r_lat;
  bit           r_busy_first;
  bit           r_busy_any;
  bit           r_overlap;
  logic [W-1:0] r_q_at_e;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Launches one op and waits (bounded) for done; r_lat counts cycles from
  // the accepting edge to the edge that ends the done cycle, -1 on timeout.
  task automatic do_op(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit now, input int glitch_at);
    int k;
    if (!now) @(negedge clk);
    start = 1'b1; signed_mode = sm; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    r_busy_first = busy;
    r_q_at_e     = quotient;
    r_busy_any   = 1'b0;
    r_overlap    = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      if (busy) r_busy_any = 1'b1;
      if (k == glitch_at) begin
        start = 1'b1; signed_mode = ~sm; dividend = 32'd77; divisor = 32'd7;
      end else if (k == glitch_at + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (busy && done) r_overlap = 1'b1;
      k++;
    end
    start = 1'b0;
    r_lat = done ? k + 1 : -1;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_unsigned();
    do_op(1'b0, 32'd100, 32'd7, 1'b0, -1);
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL u100_7_q got=%0d exp=14", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL u100_7_r got=%0d exp=2", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL u100_7_dbz got=%b exp=0", div_by_zero); end
    checks++; if (r_lat !== LAT_NORM) begin errors++; $display("FAIL u100_7_latency got=%0d exp=%0d", r_lat, LAT_NORM); end
    checks++; if (r_busy_first !== 1'b1) begin errors++; $display("FAIL u100_7_busy_at_start got=%b exp=1", r_busy_first); end
    checks++; if (r_overlap !== 1'b0) begin errors++; $display("FAIL u100_7_busy_done_overlap got=%b exp=0", r_overlap); end
    do_op(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, -1);
    checks++; if (quotient !== 32'hFFFFFFFF) begin errors++; $display("FAIL umax_1_q got=%h exp=ffffffff", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL umax_1_r got=%h exp=0", remainder); end
  endtask

  task automatic test_signed();
    do_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, -1);
    checks++; if (quotient !== 32'hFFFFFFFD) begin errors++; $display("FAIL sm7_2_q got=%h exp=fffffffd", quotient); end
    checks++; if (remainder !== 32'hFFFFFFFF) begin errors++; $display("FAIL sm7_2_r got=%h exp=ffffffff", remainder); end
    do_op(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, -1);
    checks++; if (quotient !== 32'hFFFFFFFD) begin errors++; $display("FAIL s7_m2_q got=%h exp=fffffffd", quotient); end
    checks++; if (remainder !== 32'd1) begin errors++; $display("FAIL s7_m2_r got=%h exp=1", remainder); end
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1);
    checks++; if (quotient !== 32'h80000000) begin errors++; $display("FAIL smin_m1_q got=%h exp=80000000", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL smin_m1_r got=%h exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL smin_m1_dbz got=%b exp=0", div_by_zero); end
  endtask

  task automatic test_div_by_zero();
    for (int m = 0; m < 2; m++) begin
      do_op(m[0], 32'd5, 32'd0, 1'b0, -1);
      checks++; if (quotient !== 32'hFFFFFFFF) begin errors++; $display("FAIL dbz_q mode=%0d got=%h exp=ffffffff", m, quotient); end
      checks++; if (remainder !== 32'd5) begin errors++; $display("FAIL dbz_r mode=%0d got=%h exp=5", m, remainder); end
      checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag mode=%0d got=%b exp=1", m, div_by_zero); end
      checks++; if (r_lat !== LAT_DBZ) begin errors++; $display("FAIL dbz_latency mode=%0d got=%0d exp=%0d", m, r_lat, LAT_DBZ); end
      checks++; if (r_busy_first !== 1'b0) begin errors++; $display("FAIL dbz_busy mode=%0d got=%b exp=0", m, r_busy_first); end
    end
    do_op(1'b0, 32'd9, 32'd3, 1'b0, -1);
    checks++; if (quotient !== 32'd3) begin errors++; $display("FAIL after_dbz_q got=%0d exp=3", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL after_dbz_r got=%0d exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL after_dbz_flag got=%b exp=0", div_by_zero); end
  endtask

  task automatic test_start_ignored();
    do_op(1'b0, 32'd1000, 32'd3, 1'b0, 10);
    checks++; if (quotient !== 32'd333) begin errors++; $display("FAIL ignore_q got=%0d exp=333", quotient); end
    checks++; if (remainder !== 32'd1) begin errors++; $display("FAIL ignore_r got=%0d exp=1", remainder); end
    checks++; if (r_lat !== LAT_NORM) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", r_lat, LAT_NORM); end
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 32'd20, 32'd3, 1'b0, -1);
    checks++; if (quotient !== 32'd6) begin errors++; $display("FAIL b2b_first_q got=%0d exp=6", quotient); end
    do_op(1'b0, 32'd45, 32'd6, 1'b1, -1);
    checks++; if (r_busy_first !== 1'b1) begin errors++; $display("FAIL b2b_no_idle busy got=%b exp=1", r_busy_first); end
    checks++; if (r_q_at_e !== 32'd6) begin errors++; $display("FAIL b2b_result_held got=%0d exp=6", r_q_at_e); end
    checks++; if (quotient !== 32'd7) begin errors++; $display("FAIL b2b_second_q got=%0d exp=7", quotient); end
    checks++; if (remainder !== 32'd3) begin errors++; $display("FAIL b2b_second_r got=%0d exp=3", remainder); end
    checks++; if (r_lat !== LAT_NORM) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", r_lat, LAT_NORM); end
  endtask

  task automatic test_clear();
    bit saw;
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; dividend = 32'd123456; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_pre_busy got=%b exp=1", busy); end
    clr = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_done got=%b exp=0", done); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL clr_quotient got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL clr_remainder got=%h exp=0", remainder); end
    @(negedge clk);
    clr = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL clr_no_done got=%b exp=0", saw); end
    do_op(1'b0, 32'd50, 32'd5, 1'b0, -1);
    checks++; if (quotient !== 32'd10) begin errors++; $display("FAIL clr_after_q got=%0d exp=10", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL clr_after_r got=%0d exp=0", remainder); end
    checks++; if (r_lat !== LAT_NORM) begin errors++; $display("FAIL clr_after_latency got=%0d exp=%0d", r_lat, LAT_NORM); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er;
    longint       sa, sb, qq, rr;
    bit           sm, edbz;
    int           elat;
    for (int n = 0; n < 300; n++) begin
      sm = 1'($urandom_range(0, 1));
      a  = (($urandom_range(0, 7)) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = 32'($urandom);
      endcase
      if (b == 32'd0) begin
        eq = 32'hFFFFFFFF; er = a; edbz = 1'b1; elat = LAT_DBZ;
      end else begin
        if (sm) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
        end else begin
          sa = longint'({32'd0, a});
          sb = longint'({32'd0, b});
        end
        qq = sa / sb;
        rr = sa % sb;
        eq = qq[31:0]; er = rr[31:0]; edbz = 1'b0; elat = LAT_NORM;
      end
      do_op(sm, a, b, 1'b0, -1);
      checks++; if (quotient !== eq) begin errors++; $display("FAIL rand_q n=%0d sm=%0d a=%h b=%h got=%h exp=%h", n, sm, a, b, quotient, eq); end
      checks++; if (remainder !== er) begin errors++; $display("FAIL rand_r n=%0d sm=%0d a=%h b=%h got=%h exp=%h", n, sm, a, b, remainder, er); end
      checks++; if (div_by_zero !== edbz) begin errors++; $display("FAIL rand_dbz n=%0d got=%b exp=%b", n, div_by_zero, edbz); end
      checks++; if (r_lat !== elat) begin errors++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, r_lat, elat); end
      checks++; if (r_overlap !== 1'b0) begin errors++; $display("FAIL rand_busy_done_overlap n=%0d got=%b exp=0", n, r_overlap); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_start_ignored();
    test_back_to_back();
    test_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
